ay_regs: RTL and testbench

CPU-side register file for the AY-3-891x core: accepts Z8S180 I/O address-latch and data-write strobes, holds the 16 PSG registers, and drives the tone, noise, mixer, amplitude, envelope and I/O-port fields consumed by the generator blocks. It is the writer end of the envelope interface: it produces `env_period`, `env_shape` and the one-cycle `shape_tick` consumed by `ay_env`. It also returns registered read data with the chip's unused-bit masking.

---
 rtl/ay_regs.sv | 119 +++++++++++
 tb/tb_ay_regs.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ay_regs.sv
// AY-3-891x CPU-side register file: address latch, 16 masked PSG registers,
// field outputs for the generators, envelope restart tick and registered readback.
module ay_regs #(
  parameter logic [3:0] ADDR_HI = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        addr_tick,
  input  logic        wr_tick,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  input  logic [7:0]  ioa_in,
  input  logic [7:0]  iob_in,
  output logic [11:0] tone_a_period,
  output logic [11:0] tone_b_period,
  output logic [11:0] tone_c_period,
  output logic [4:0]  noise_period,
  output logic [2:0]  tone_en_n,
  output logic [2:0]  noise_en_n,
  output logic        ioa_oe,
  output logic        iob_oe,
  output logic [4:0]  amp_a,
  output logic [4:0]  amp_b,
  output logic [4:0]  amp_c,
  output logic [15:0] env_period,
  output logic [3:0]  env_shape,
  output logic        shape_tick,
  output logic [7:0]  ioa_out,
  output logic [7:0]  iob_out
);

  localparam int unsigned NREG    = 16;
  localparam int unsigned DW      = 8;
  localparam logic [3:0]  R_SHAPE = 4'd13;
  localparam logic [3:0]  R_IOA   = 4'd14;
  localparam logic [3:0]  R_IOB   = 4'd15;

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [3:0]    addr_q, addr_d;
  logic          addr_valid_q, addr_valid_d;
  logic          shape_tick_q, shape_tick_d;
  logic [DW-1:0] dout_q, dout_d;

  // Implemented bits per register; unused bits are never stored.
  function automatic logic [DW-1:0] wmask(input logic [3:0] a);
    case (a)
      4'd1, 4'd3, 4'd5, 4'd13: wmask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10: wmask = 8'h1F;
      default:                 wmask = 8'hFF;
    endcase
  endfunction

  // Next state: write uses the pre-edge address; readback uses post-edge state.
  always_comb begin
    regs_d       = regs_q;
    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    shape_tick_d = 1'b0;
    dout_d       = 8'hFF;

    if (wr_tick && addr_valid_q) begin
      regs_d[addr_q] = din & wmask(addr_q);
      shape_tick_d   = (addr_q == R_SHAPE);
    end

    if (addr_tick) begin
      if (din[7:4] == ADDR_HI) begin
        addr_d       = din[3:0];
        addr_valid_d = 1'b1;
      end else begin
        addr_valid_d = 1'b0;
      end
    end

    if (addr_valid_d) begin
      case (addr_d)
        R_IOA:   dout_d = regs_d[7][6] ? regs_d[R_IOA] : ioa_in;
        R_IOB:   dout_d = regs_d[7][7] ? regs_d[R_IOB] : iob_in;
        default: dout_d = regs_d[addr_d];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      addr_q       <= '0;
      addr_valid_q <= 1'b1;
      shape_tick_q <= 1'b0;
      dout_q       <= '0;
    end else begin
      regs_q       <= regs_d;
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      shape_tick_q <= shape_tick_d;
      dout_q       <= dout_d;
    end
  end

  assign dout          = dout_q;
  assign shape_tick    = shape_tick_q;
  assign tone_a_period = {regs_q[1][3:0], regs_q[0]};
  assign tone_b_period = {regs_q[3][3:0], regs_q[2]};
  assign tone_c_period = {regs_q[5][3:0], regs_q[4]};
  assign noise_period  = regs_q[6][4:0];
  assign tone_en_n     = regs_q[7][2:0];
  assign noise_en_n    = regs_q[7][5:3];
  assign ioa_oe        = regs_q[7][6];
  assign iob_oe        = regs_q[7][7];
  assign amp_a         = regs_q[8][4:0];
  assign amp_b         = regs_q[9][4:0];
  assign amp_c         = regs_q[10][4:0];
  assign env_period    = {regs_q[12], regs_q[11]};
  assign env_shape     = regs_q[13][3:0];
  assign ioa_out       = regs_q[14];
  assign iob_out       = regs_q[15];

endmodule

// File: tb/tb_ay_regs.sv
// Directed self-checking bench for ay_regs: inputs driven and outputs sampled on negedge.
module tb_ay_regs;

  logic        clk = 1'b0;
  logic        reset, addr_tick, wr_tick;
  logic [7:0]  din, dout, ioa_in, iob_in;
  logic [11:0] tone_a_period, tone_b_period, tone_c_period;
  logic [4:0]  noise_period, amp_a, amp_b, amp_c;
  logic [2:0]  tone_en_n, noise_en_n;
  logic        ioa_oe, iob_oe, shape_tick;
  logic [15:0] env_period;
  logic [3:0]  env_shape;
  logic [7:0]  ioa_out, iob_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ay_regs #(.ADDR_HI(4'h0)) dut (
    .clk(clk), .reset(reset), .addr_tick(addr_tick), .wr_tick(wr_tick),
    .din(din), .dout(dout), .ioa_in(ioa_in), .iob_in(iob_in),
    .tone_a_period(tone_a_period), .tone_b_period(tone_b_period),
    .tone_c_period(tone_c_period), .noise_period(noise_period),
    .tone_en_n(tone_en_n), .noise_en_n(noise_en_n),
    .ioa_oe(ioa_oe), .iob_oe(iob_oe),
    .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
    .env_period(env_period), .env_shape(env_shape), .shape_tick(shape_tick),
    .ioa_out(ioa_out), .iob_out(iob_out)
  );

  task automatic latch(input logic [7:0] a);
    din = a; addr_tick = 1'b1;
    @(negedge clk);
    addr_tick = 1'b0;
  endtask

  task automatic write(input logic [7:0] d);
    din = d; wr_tick = 1'b1;
    @(negedge clk);
    wr_tick = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; addr_tick = 1'b0; wr_tick = 1'b0; din = 8'h00;
    ioa_in = 8'h00; iob_in = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle();
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout got=%h exp=00", dout); end
    n_checks++; if ({tone_en_n, noise_en_n, ioa_oe, iob_oe} !== 8'h00) begin n_fail++; $display("FAIL reset_mixer got=%b exp=0", {tone_en_n, noise_en_n, ioa_oe, iob_oe}); end
    n_checks++; if (shape_tick !== 1'b0 || env_shape !== 4'h0 || env_period !== 16'h0) begin n_fail++; $display("FAIL reset_env tick=%b shape=%h per=%h exp=0", shape_tick, env_shape, env_period); end
  endtask

  task automatic test_shape_write();
    latch(8'h0D);
    write(8'hFE);
    n_checks++; if (env_shape !== 4'hE) begin n_fail++; $display("FAIL shape_val got=%h exp=E", env_shape); end
    n_checks++; if (shape_tick !== 1'b1) begin n_fail++; $display("FAIL shape_tick_hi got=%b exp=1", shape_tick); end
    n_checks++; if (dout !== 8'h0E) begin n_fail++; $display("FAIL shape_dout got=%h exp=0E", dout); end
    idle();
    n_checks++; if (shape_tick !== 1'b0) begin n_fail++; $display("FAIL shape_tick_lo got=%b exp=0", shape_tick); end
  endtask

  task automatic test_env_period();
    latch(8'h0B); write(8'h0A);
    n_checks++; if (shape_tick !== 1'b0) begin n_fail++; $display("FAIL r11_no_tick got=%b exp=0", shape_tick); end
    latch(8'h0C); write(8'h00);
    n_checks++; if (shape_tick !== 1'b0) begin n_fail++; $display("FAIL r12_no_tick got=%b exp=0", shape_tick); end
    n_checks++; if (env_period !== 16'h000A) begin n_fail++; $display("FAIL env_period got=%h exp=000A", env_period); end
    latch(8'h0D); write(8'h0A);
    n_checks++; if (shape_tick !== 1'b1 || env_shape !== 4'hA) begin n_fail++; $display("FAIL repeat1 tick=%b shape=%h exp=1/A", shape_tick, env_shape); end
    idle();
    n_checks++; if (shape_tick !== 1'b0) begin n_fail++; $display("FAIL repeat_gap got=%b exp=0", shape_tick); end
    write(8'h0A);
    n_checks++; if (shape_tick !== 1'b1) begin n_fail++; $display("FAIL repeat2 got=%b exp=1", shape_tick); end
    idle();
    n_checks++; if (shape_tick !== 1'b0) begin n_fail++; $display("FAIL repeat2_end got=%b exp=0", shape_tick); end
  endtask

  task automatic test_back_to_back();
    din = 8'h0A; wr_tick = 1'b1;
    @(negedge clk);
    n_checks++; if (shape_tick !== 1'b1) begin n_fail++; $display("FAIL b2b_first got=%b exp=1", shape_tick); end
    @(negedge clk);
    wr_tick = 1'b0;
    n_checks++; if (shape_tick !== 1'b1) begin n_fail++; $display("FAIL b2b_second got=%b exp=1", shape_tick); end
    idle();
    n_checks++; if (shape_tick !== 1'b0) begin n_fail++; $display("FAIL b2b_end got=%b exp=0", shape_tick); end
  endtask

  task automatic test_bad_cs();
    latch(8'h1D);
    n_checks++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL badcs_dout got=%h exp=FF", dout); end
    write(8'h05);
    n_checks++; if (env_shape !== 4'hA || shape_tick !== 1'b0) begin n_fail++; $display("FAIL badcs_write shape=%h tick=%b exp=A/0", env_shape, shape_tick); end
    n_checks++; if (dout !== 8'hFF) begin n_fail++; $display("FAIL badcs_dout2 got=%h exp=FF", dout); end
    latch(8'h0D);
    n_checks++; if (dout !== 8'h0A) begin n_fail++; $display("FAIL relatch_dout got=%h exp=0A", dout); end
  endtask

  task automatic test_masking();
    latch(8'h01); write(8'hFF);
    n_checks++; if (tone_a_period[11:8] !== 4'hF) begin n_fail++; $display("FAIL r1_field got=%h exp=F", tone_a_period[11:8]); end
    n_checks++; if (dout !== 8'h0F) begin n_fail++; $display("FAIL r1_read got=%h exp=0F", dout); end
    latch(8'h08); write(8'hFF);
    n_checks++; if (amp_a !== 5'h1F) begin n_fail++; $display("FAIL amp_a got=%h exp=1F", amp_a); end
    n_checks++; if (dout !== 8'h1F) begin n_fail++; $display("FAIL r8_read got=%h exp=1F", dout); end
    latch(8'h06); write(8'hE7);
    n_checks++; if (noise_period !== 5'h07 || dout !== 8'h07) begin n_fail++; $display("FAIL r6 field=%h read=%h exp=07/07", noise_period, dout); end
  endtask

  task automatic test_ports();
    ioa_in = 8'h5A; iob_in = 8'hA5;
    latch(8'h07); write(8'h00);
    latch(8'h0E); write(8'hC3);
    n_checks++; if (dout !== 8'h5A) begin n_fail++; $display("FAIL ioa_input got=%h exp=5A", dout); end
    latch(8'h0F); write(8'h3C);
    n_checks++; if (dout !== 8'hA5) begin n_fail++; $display("FAIL iob_input got=%h exp=A5", dout); end
    latch(8'h07); write(8'h40);
    n_checks++; if (ioa_oe !== 1'b1 || iob_oe !== 1'b0) begin n_fail++; $display("FAIL oe got=%b%b exp=01", iob_oe, ioa_oe); end
    latch(8'h0E);
    n_checks++; if (dout !== 8'hC3 || ioa_out !== 8'hC3) begin n_fail++; $display("FAIL ioa_output read=%h out=%h exp=C3", dout, ioa_out); end
    latch(8'h0F);
    n_checks++; if (dout !== 8'hA5 || iob_out !== 8'h3C) begin n_fail++; $display("FAIL iob_still_in read=%h out=%h exp=A5/3C", dout, iob_out); end
  endtask

  task automatic test_simultaneous();
    latch(8'h02); write(8'h33);
    latch(8'h00);
    din = 8'h02; addr_tick = 1'b1; wr_tick = 1'b1;
    @(negedge clk);
    addr_tick = 1'b0; wr_tick = 1'b0;
    n_checks++; if (tone_a_period !== 12'hF02) begin n_fail++; $display("FAIL simul_r0 got=%h exp=F02", tone_a_period); end
    n_checks++; if (tone_b_period !== 12'h033) begin n_fail++; $display("FAIL simul_r2 got=%h exp=033", tone_b_period); end
    n_checks++; if (dout !== 8'h33) begin n_fail++; $display("FAIL simul_dout got=%h exp=33", dout); end
  endtask

  task automatic test_reset_mid();
    latch(8'h0D);
    reset = 1'b1; idle(); reset = 1'b0;
    write(8'h44);
    n_checks++; if (tone_a_period !== 12'h044) begin n_fail++; $display("FAIL rstmid_r0 got=%h exp=044", tone_a_period); end
    n_checks++; if (env_shape !== 4'h0 || shape_tick !== 1'b0) begin n_fail++; $display("FAIL rstmid_env shape=%h tick=%b exp=0/0", env_shape, shape_tick); end
    latch(8'h0D);
    din = 8'h0B; wr_tick = 1'b1; reset = 1'b1;
    @(negedge clk);
    wr_tick = 1'b0; reset = 1'b0;
    n_checks++; if (shape_tick !== 1'b0 || env_shape !== 4'h0) begin n_fail++; $display("FAIL rst_wins tick=%b shape=%h exp=0/0", shape_tick, env_shape); end
    n_checks++; if (dout !== 8'h00 || tone_a_period !== 12'h000) begin n_fail++; $display("FAIL rst_wins_regs dout=%h r0=%h exp=00/000", dout, tone_a_period); end
  endtask

  initial begin
    test_reset();
    test_shape_write();
    test_env_period();
    test_back_to_back();
    test_bad_cs();
    test_masking();
    test_ports();
    test_simultaneous();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
